trail_sequencer: RTL

- Clock-domain frame sequencer for the VGA diagonal-trail renderer.
- Detects frame boundaries from the sync generator's vsync and advances a 9-bit animation frame number under run/pause/single-step/reverse/speed control.
- Publishes registered per-lag frame offsets (frame_no − i) that stay stable for a whole frame.
- Replaces the free-running frame counter clocked directly on vsync; the pixel-compare datapath consumes its outputs.

---
 rtl/trail_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/trail_sequencer.sv
// Frame sequencer for the diagonal-trail renderer: detects vsync rising edges and
// advances a frame number under run/pause/step/reverse/speed control, publishing lag offsets.
module trail_sequencer #(
  parameter int N_LAG = 5,
  parameter int FW    = 9,
  parameter int DW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               cmd_run,
  input  logic               cmd_pause,
  input  logic               cmd_step,
  input  logic               dir,
  input  logic [DW-1:0]      speed,
  output logic [FW-1:0]      frame_no,
  output logic [N_LAG*FW-1:0] lag_offs,
  output logic               frame_tick,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_PAUSED    = 2'd1,
    ST_STEP_PEND = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic                vsync_q;
  logic [DW-1:0]       div_cnt, div_nxt;
  logic                edge_det;
  logic                advance;
  logic [FW-1:0]       frame_nxt;
  logic [N_LAG*FW-1:0] lag_nxt;

  assign edge_det = vsync & ~vsync_q;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= 1'b1;
      state_q    <= ST_RUN;
      div_cnt    <= '0;
      frame_no   <= '0;
      lag_offs   <= lag_nxt;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      state_q    <= state_nxt;
      div_cnt    <= div_nxt;
      frame_no   <= frame_nxt;
      lag_offs   <= lag_nxt;
      frame_tick <= advance;
    end
  end

  always_comb begin
    state_nxt = state_q;
    div_nxt   = div_cnt;
    advance   = 1'b0;

    // Advance uses the registered state; commands below only pick the next state.
    if (edge_det) begin
      unique case (state_q)
        ST_RUN: begin
          if (div_cnt >= speed) begin
            advance = 1'b1;
            div_nxt = '0;
          end else begin
            div_nxt = div_cnt + 1'b1;
          end
        end
        ST_STEP_PEND: begin
          advance   = 1'b1;
          div_nxt   = '0;
          state_nxt = ST_PAUSED;
        end
        default: ;
      endcase
    end

    if (cmd_run)
      state_nxt = ST_RUN;
    else if (cmd_pause)
      state_nxt = ST_PAUSED;
    else if (cmd_step && state_q == ST_PAUSED)
      state_nxt = ST_STEP_PEND;
  end

  always_comb begin
    frame_nxt = frame_no;
    if (reset)
      frame_nxt = '0;
    else if (advance)
      frame_nxt = dir ? frame_no - 1'b1 : frame_no + 1'b1;
  end

  // Offsets are rebuilt every cycle from the next frame value, so they only move on advance.
  always_comb begin
    lag_nxt = '0;
    for (int unsigned i = 0; i < N_LAG; i++)
      lag_nxt[i*FW +: FW] = frame_nxt - FW'(i);
  end

endmodule
